krypton_text_renderer: RTL

//  80x30 text-mode pixel generator, directly downstream of the sync generator.

---
 rtl/krypton_text_renderer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/krypton_text_renderer.sv
// 80x30 text-mode pixel generator: VRAM/font fetch pipeline, 16-entry palette,
// blinking underline cursor, RGB444 and syncs delayed 4 cycles to match the pixels.
module krypton_text_renderer #(
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [9:0]  i_HCount,
  input  logic [9:0]  i_VCount,
  input  logic        i_HSync,
  input  logic        i_VSync,
  output logic [11:0] o_VramAddr,
  input  logic [15:0] i_VramData,
  output logic [11:0] o_FontAddr,
  input  logic [7:0]  i_FontData,
  input  logic        i_PalWe,
  input  logic [3:0]  i_PalAddr,
  input  logic [11:0] i_PalData,
  input  logic        i_CursorEn,
  input  logic [6:0]  i_CursorCol,
  input  logic [4:0]  i_CursorRow,
  output logic [3:0]  o_Red,
  output logic [3:0]  o_Green,
  output logic [3:0]  o_Blue,
  output logic        o_HSync,
  output logic        o_VSync
);

  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_t;

  logic [6:0]  s0_col;
  logic [4:0]  s0_row;
  logic        s0_active, s0_hit;

  logic [2:0]  s1_xbit, s2_xbit;
  logic [3:0]  s1_vrow, s2_vrow;
  logic        s1_active, s2_active, s3_active;
  logic        s1_hit, s2_hit;
  logic [3:0]  s2_fg, s2_bg, s3_index;
  logic        glyph_bit;

  logic [3:0]  hs_pipe, vs_pipe;
  logic [11:0] palette [16];
  logic        vsync_q;
  logic [BW-1:0] blink_cnt;
  phase_t      phase;

  assign s0_col    = i_HCount[9:3];
  assign s0_row    = i_VCount[8:4];
  assign s0_active = (i_HCount < H_VIS) && (i_VCount < V_VIS) && (int'(s0_row) < ROWS);
  assign s0_hit    = (s0_col == i_CursorCol) && (s0_row == i_CursorRow);

  always_comb begin
    glyph_bit = i_FontData[3'd7 - s2_xbit];
    if (s2_hit && (s2_vrow >= 4'd14) && i_CursorEn && (phase == PH_VISIBLE))
      glyph_bit = 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_VramAddr <= '0;
      o_FontAddr <= '0;
      s1_xbit    <= '0;
      s1_vrow    <= '0;
      s1_active  <= 1'b0;
      s1_hit     <= 1'b0;
      s2_xbit    <= '0;
      s2_vrow    <= '0;
      s2_active  <= 1'b0;
      s2_hit     <= 1'b0;
      s2_fg      <= '0;
      s2_bg      <= '0;
      s3_index   <= '0;
      s3_active  <= 1'b0;
      o_Red      <= '0;
      o_Green    <= '0;
      o_Blue     <= '0;
    end else begin
      // Address only moves on visible pixels so blanking never disturbs VRAM.
      if (s0_active)
        o_VramAddr <= 12'(int'(s0_row) * COLS + int'(s0_col));
      s1_xbit   <= i_HCount[2:0];
      s1_vrow   <= i_VCount[3:0];
      s1_active <= s0_active;
      s1_hit    <= s0_hit;

      o_FontAddr <= {i_VramData[7:0], s1_vrow};
      s2_fg      <= i_VramData[11:8];
      s2_bg      <= i_VramData[15:12];
      s2_xbit    <= s1_xbit;
      s2_vrow    <= s1_vrow;
      s2_active  <= s1_active;
      s2_hit     <= s1_hit;

      s3_index  <= glyph_bit ? s2_fg : s2_bg;
      s3_active <= s2_active;

      {o_Red, o_Green, o_Blue} <= s3_active ? palette[s3_index] : '0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe <= {hs_pipe[2:0], i_HSync};
      vs_pipe <= {vs_pipe[2:0], i_VSync};
    end
  end

  assign o_HSync = hs_pipe[3];
  assign o_VSync = vs_pipe[3];

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int unsigned i = 0; i < 16; i++)
        palette[i] <= {3{4'(i)}};
    end else if (i_PalWe) begin
      palette[i_PalAddr] <= i_PalData;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vsync_q   <= 1'b1;
      blink_cnt <= '0;
      phase     <= PH_VISIBLE;
    end else begin
      vsync_q <= i_VSync;
      if (vsync_q && !i_VSync) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule
